// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared constants and types for the register-file writeback path.
//   XLEN     : integer register width
//   REG_AW   : register address width
//   NREGS    : number of architectural registers
//   wb_req_t : one buffered write, {rd, data}
//   REQ_W    : flat width of wb_req_t, used on module ports
//   reg_mask : one-hot decode of a register address
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    localparam int REQ_W = $bits(wb_req_t);

    function automatic logic [NREGS-1:0] reg_mask(input logic [REG_AW-1:0] rd);
        logic [NREGS-1:0] m;
        m     = '0;
        m[rd] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Small circular buffer holding long-latency results until the register-file
// write port is free. Push is ignored when full, pop is ignored when empty.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_push_data   write one {rd,data} entry
//   i_pop            retire the head entry
//   o_head           oldest entry (valid only when !o_empty)
//   o_full, o_empty  occupancy flags
// -----------------------------------------------------------------------------
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [REQ_W-1:0] i_push_data,
    input  logic             i_pop,
    output logic [REQ_W-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [REQ_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single register-file write port between the in-order ALU
// writeback and a long-latency unit. Long-unit results are buffered in
// wb_fifo; a starve counter raises stall_req so buffered results always
// drain. A pending-destination scoreboard answers decode hazard queries.
// Ports:
//   i_clk, i_rst_n                        clock, asynchronous active-low reset
//   i_alu_wb_valid/_rd/_data              ALU writeback request
//   i_lu_issue_valid/_rd                  long op issued, marks rd pending
//   i_lu_done_valid/_rd/_data, o_lu_done_ready   long op result handshake
//   i_dec_rs1/_rs2/_rd, i_dec_use_*       decode operand query
//   o_sb_hazard                           any used operand pending (comb)
//   o_stall_req                           core must hold decode, idle ALU wb
//   o_rf_we/_waddr/_wdata                 registered write port
// -----------------------------------------------------------------------------
module wb_port_arbiter
    import riscv_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_alu_wb_valid,
    input  logic [REG_AW-1:0] i_alu_wb_rd,
    input  logic [XLEN-1:0]   i_alu_wb_data,
    input  logic              i_lu_issue_valid,
    input  logic [REG_AW-1:0] i_lu_issue_rd,
    input  logic              i_lu_done_valid,
    input  logic [REG_AW-1:0] i_lu_done_rd,
    input  logic [XLEN-1:0]   i_lu_done_data,
    output logic              o_lu_done_ready,
    input  logic [REG_AW-1:0] i_dec_rs1,
    input  logic [REG_AW-1:0] i_dec_rs2,
    input  logic [REG_AW-1:0] i_dec_rd,
    input  logic              i_dec_use_rs1,
    input  logic              i_dec_use_rs2,
    input  logic              i_dec_use_rd,
    output logic              o_sb_hazard,
    output logic              o_stall_req,
    output logic              o_rf_we,
    output logic [REG_AW-1:0] o_rf_waddr,
    output logic [XLEN-1:0]   o_rf_wdata
);

    localparam int CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_MAX - 1);

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_alu_sel;
    logic             w_head_blocked;
    logic             w_starve_hit;
    logic [REQ_W-1:0] w_push_bits;
    logic [REQ_W-1:0] w_head_bits;
    wb_req_t          w_head;
    logic [NREGS-1:0] w_pend_set;
    logic [NREGS-1:0] w_pend_clr;

    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_stall_req;
    logic [NREGS-1:0]  r_pend;
    logic              r_rf_we;
    logic [REG_AW-1:0] r_rf_waddr;
    logic [XLEN-1:0]   r_rf_wdata;

    assign w_push_bits = {i_lu_done_rd, i_lu_done_data};
    assign w_push      = i_lu_done_valid && !w_fifo_full;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_bits),
        .i_pop       (w_pop),
        .o_head      (w_head_bits),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign w_head = wb_req_t'(w_head_bits);

    // The head takes the port when the ALU is idle, or once starvation has
    // raised stall_req; an ALU request during a stall is a core fault and
    // still loses to the head.
    assign w_pop          = !w_fifo_empty && (!i_alu_wb_valid || r_stall_req);
    assign w_alu_sel      = i_alu_wb_valid && !w_pop;
    assign w_head_blocked = !w_fifo_empty && !w_pop;
    assign w_starve_hit   = w_head_blocked && (r_starve_cnt == STARVE_LAST);

    always_comb begin
        w_pend_set = '0;
        w_pend_clr = '0;
        if (i_lu_issue_valid && (i_lu_issue_rd != '0)) begin
            w_pend_set = reg_mask(i_lu_issue_rd);
        end
        if (w_pop) begin
            w_pend_clr = reg_mask(w_head.rd);
        end
    end

    // Pre-edge scoreboard only: a register retiring this cycle still reads
    // as pending until the following cycle.
    assign o_sb_hazard = (i_dec_use_rs1 && r_pend[i_dec_rs1])
                       | (i_dec_use_rs2 && r_pend[i_dec_rs2])
                       | (i_dec_use_rd  && r_pend[i_dec_rd]);

    assign o_lu_done_ready = !w_fifo_full;
    assign o_stall_req     = r_stall_req;
    assign o_rf_we         = r_rf_we;
    assign o_rf_waddr      = r_rf_waddr;
    assign o_rf_wdata      = r_rf_wdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= '0;
            r_stall_req  <= 1'b0;
            r_pend       <= '0;
        end else begin
            if (w_pop) begin
                r_starve_cnt <= '0;
            end else if (w_head_blocked && (r_starve_cnt != STARVE_LAST)) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end

            if (w_pop) begin
                r_stall_req <= 1'b0;
            end else if (w_starve_hit) begin
                r_stall_req <= 1'b1;
            end

            // Set after clear so an issue to the retiring rd keeps it pending.
            r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else if (w_alu_sel) begin
            r_rf_we    <= (i_alu_wb_rd != '0);
            r_rf_waddr <= i_alu_wb_rd;
            r_rf_wdata <= i_alu_wb_data;
        end else if (w_pop) begin
            r_rf_we    <= (w_head.rd != '0);
            r_rf_waddr <= w_head.rd;
            r_rf_wdata <= w_head.data;
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int FIFO_DEPTH = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [63:0] alu_wb_data;
    logic        lu_issue_valid;
    logic [4:0]  lu_issue_rd;
    logic        lu_done_valid;
    logic [4:0]  lu_done_rd;
    logic [63:0] lu_done_data;
    logic        lu_done_ready;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_use_rs1, dec_use_rs2, dec_use_rd;
    logic        sb_hazard;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;

    wb_port_arbiter #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_alu_wb_valid   (alu_wb_valid),
        .i_alu_wb_rd      (alu_wb_rd),
        .i_alu_wb_data    (alu_wb_data),
        .i_lu_issue_valid (lu_issue_valid),
        .i_lu_issue_rd    (lu_issue_rd),
        .i_lu_done_valid  (lu_done_valid),
        .i_lu_done_rd     (lu_done_rd),
        .i_lu_done_data   (lu_done_data),
        .o_lu_done_ready  (lu_done_ready),
        .i_dec_rs1        (dec_rs1),
        .i_dec_rs2        (dec_rs2),
        .i_dec_rd         (dec_rd),
        .i_dec_use_rs1    (dec_use_rs1),
        .i_dec_use_rs2    (dec_use_rs2),
        .i_dec_use_rd     (dec_use_rd),
        .o_sb_hazard      (sb_hazard),
        .o_stall_req      (stall_req),
        .o_rf_we          (rf_we),
        .o_rf_waddr       (rf_waddr),
        .o_rf_wdata       (rf_wdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of buffered results, a pending flag per
    // register, and how many cycles the current head has been passed over.
    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    ent_t        m_q[$];
    bit          m_pend[32];
    int          m_blocked;
    bit          m_stall;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [63:0] m_wdata;

    task automatic m_reset();
        m_q.delete();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_blocked = 0;
        m_stall   = 1'b0;
        m_we      = 1'b0;
        m_waddr   = '0;
        m_wdata   = '0;
    endtask

    function automatic bit exp_hazard();
        return (dec_use_rs1 && m_pend[dec_rs1]) || (dec_use_rs2 && m_pend[dec_rs2])
            || (dec_use_rd && m_pend[dec_rd]);
    endfunction

    task automatic idle();
        alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
        lu_issue_valid = 0; lu_issue_rd = 0;
        lu_done_valid = 0; lu_done_rd = 0; lu_done_data = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        dec_use_rs1 = 0; dec_use_rs2 = 0; dec_use_rd = 0;
    endtask

    // Advance one clock; the model applies the arbitration rules to the
    // inputs present at the edge. Returns at edge + 1.
    task automatic cycle();
        int   depth_before;
        bit   head_goes;
        bit   alu_goes;
        bit   accept;
        ent_t head;
        depth_before = m_q.size();
        head_goes = (depth_before > 0) && (!alu_wb_valid || m_stall);
        alu_goes  = alu_wb_valid && !head_goes;
        accept    = lu_done_valid && (depth_before < FIFO_DEPTH);
        @(posedge clk);
        #1;
        if (head_goes) begin
            head = m_q.pop_front();
            m_pend[head.rd] = 1'b0;
        end
        if (lu_issue_valid && lu_issue_rd != 0) m_pend[lu_issue_rd] = 1'b1;
        if (alu_goes) begin
            m_we = (alu_wb_rd != 0); m_waddr = alu_wb_rd; m_wdata = alu_wb_data;
        end else if (head_goes) begin
            m_we = (head.rd != 0); m_waddr = head.rd; m_wdata = head.data;
        end else begin
            m_we = 1'b0;
        end
        if (head_goes) begin
            m_blocked = 0;
            m_stall   = 1'b0;
        end else if (depth_before > 0) begin
            m_blocked++;
            if (m_blocked >= STARVE_MAX) m_stall = 1'b1;
        end
        if (accept) m_q.push_back('{rd: lu_done_rd, data: lu_done_data});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            alu_wb_valid = 1'($urandom_range(0, 1)); alu_wb_rd = 5'($urandom_range(0, 31));
            alu_wb_data = {$urandom(), $urandom()};
            lu_issue_valid = 1'($urandom_range(0, 1)); lu_issue_rd = 5'($urandom_range(0, 31));
            lu_done_valid = 1'($urandom_range(0, 1)); lu_done_rd = 5'($urandom_range(0, 31));
            lu_done_data = {$urandom(), $urandom()};
            dec_rs1 = 5'($urandom_range(0, 31)); dec_rs2 = 5'($urandom_range(0, 31));
            dec_rd = 5'($urandom_range(0, 31));
            dec_use_rs1 = 1; dec_use_rs2 = 1; dec_use_rd = 1;
            #1;
            n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
            n_tests++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr: got %0d want 0", rf_waddr); end
            n_tests++; if (rf_wdata !== 64'd0) begin n_fail++; $display("FAIL reset_rf_wdata: got %0h want 0", rf_wdata); end
            n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_req); end
            n_tests++; if (lu_done_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", lu_done_ready); end
            n_tests++; if (sb_hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b want 0", sb_hazard); end
        end
        idle();
        rst_n = 1'b1;
        cycle();
        alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 64'd7;
        #1;
        n_tests++; if (lu_done_ready !== 1'b1) begin n_fail++; $display("FAIL first_ready: got %b want 1", lu_done_ready); end
        n_tests++; if (sb_hazard !== 1'b0) begin n_fail++; $display("FAIL first_hazard: got %b want 0", sb_hazard); end
        cycle();
        n_tests++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL alu_x5_we: got %b want 1", rf_we); end
        n_tests++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL alu_x5_waddr: got %0d want 5", rf_waddr); end
        n_tests++; if (rf_wdata !== 64'd7) begin n_fail++; $display("FAIL alu_x5_wdata: got %0h want 7", rf_wdata); end
        idle();
    endtask

    task automatic test_hazard();
        idle();
        lu_issue_valid = 1; lu_issue_rd = 12;
        cycle();
        idle();
        dec_rs1 = 12; dec_use_rs1 = 1;
        #1;
        n_tests++; if (sb_hazard !== 1'b1) begin n_fail++; $display("FAIL hazard_x12_set: got %b want 1", sb_hazard); end
        lu_done_valid = 1; lu_done_rd = 12; lu_done_data = 64'd168;
        cycle();
        lu_done_valid = 0;
        #1;
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL lu_no_bypass: got %b want 0", rf_we); end
        n_tests++; if (sb_hazard !== 1'b1) begin n_fail++; $display("FAIL hazard_x12_buffered: got %b want 1", sb_hazard); end
        cycle();
        n_tests++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL lu_x12_we: got %b want 1", rf_we); end
        n_tests++; if (rf_waddr !== 5'd12) begin n_fail++; $display("FAIL lu_x12_waddr: got %0d want 12", rf_waddr); end
        n_tests++; if (rf_wdata !== 64'd168) begin n_fail++; $display("FAIL lu_x12_wdata: got %0h want a8", rf_wdata); end
        #1;
        n_tests++; if (sb_hazard !== 1'b0) begin n_fail++; $display("FAIL hazard_x12_cleared: got %b want 0", sb_hazard); end
        idle();
    endtask

    task automatic test_starve();
        logic want_stall;
        idle();
        lu_issue_valid = 1; lu_issue_rd = 20;
        cycle();
        idle();
        alu_wb_valid = 1; alu_wb_rd = 3; alu_wb_data = 64'h33;
        lu_done_valid = 1; lu_done_rd = 20; lu_done_data = 64'd12;
        cycle();
        lu_done_valid = 0;
        for (int i = 1; i <= STARVE_MAX; i++) begin
            alu_wb_data = 64'h30 + 64'(i);
            cycle();
            want_stall = (i == STARVE_MAX);
            n_tests++; if (stall_req !== want_stall) begin n_fail++; $display("FAIL starve_stall_%0d: got %b want %b", i, stall_req, want_stall); end
            n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin n_fail++; $display("FAIL starve_alu_%0d: got we=%b addr=%0d want we=1 addr=3", i, rf_we, rf_waddr); end
        end
        alu_wb_valid = 0;
        cycle();
        n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd20 || rf_wdata !== 64'd12) begin n_fail++; $display("FAIL starve_drain: got we=%b addr=%0d data=%0h want we=1 addr=20 data=c", rf_we, rf_waddr, rf_wdata); end
        n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL starve_release: got %b want 0", stall_req); end
        dec_rs1 = 20; dec_use_rs1 = 1;
        #1;
        n_tests++; if (sb_hazard !== 1'b0) begin n_fail++; $display("FAIL starve_x20_cleared: got %b want 0", sb_hazard); end
        idle();
    endtask

    task automatic test_full();
        logic [4:0]  got_rd[$];
        logic [63:0] got_data[$];
        bit          acc;
        idle();
        alu_wb_valid = 1; alu_wb_rd = 7; alu_wb_data = 64'h77;
        lu_done_valid = 1; lu_done_rd = 21; lu_done_data = 64'hA1;
        cycle();
        lu_done_rd = 22; lu_done_data = 64'hA2;
        cycle();
        lu_done_rd = 23; lu_done_data = 64'hA3;
        #1;
        n_tests++; if (lu_done_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", lu_done_ready); end
        for (int c = 0; c < 40 && got_rd.size() < 3; c++) begin
            alu_wb_valid = !m_stall;
            #1;
            n_tests++; if (lu_done_ready !== (m_q.size() < FIFO_DEPTH)) begin n_fail++; $display("FAIL full_ready_c%0d: got %b want %b", c, lu_done_ready, m_q.size() < FIFO_DEPTH); end
            acc = lu_done_valid && (m_q.size() < FIFO_DEPTH);
            cycle();
            n_tests++; if (rf_we !== m_we) begin n_fail++; $display("FAIL full_we_c%0d: got %b want %b", c, rf_we, m_we); end
            if (acc) lu_done_valid = 0;
            if (rf_we && rf_waddr >= 5'd21 && rf_waddr <= 5'd23) begin
                got_rd.push_back(rf_waddr);
                got_data.push_back(rf_wdata);
            end
        end
        n_tests++;
        if (got_rd.size() != 3) begin
            n_fail++; $display("FAIL full_drain_timeout: got %0d retired want 3", got_rd.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++; if (got_rd[i] !== 5'(21 + i) || got_data[i] !== 64'hA1 + 64'(i)) begin n_fail++; $display("FAIL full_order_%0d: got x%0d=%0h want x%0d=%0h", i, got_rd[i], got_data[i], 21 + i, 64'hA1 + 64'(i)); end
            end
        end
        idle();
    endtask

    task automatic test_rd0();
        idle();
        lu_done_valid = 1; lu_done_rd = 0; lu_done_data = 64'hFF;
        cycle();
        idle();
        cycle();
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rd0_we: got %b want 0", rf_we); end
        dec_rs1 = 0; dec_use_rs1 = 1;
        #1;
        n_tests++; if (sb_hazard !== 1'b0) begin n_fail++; $display("FAIL rd0_hazard: got %b want 0", sb_hazard); end
        n_tests++; if (lu_done_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_popped: got ready %b want 1", lu_done_ready); end
        idle();
        lu_issue_valid = 1; lu_issue_rd = 9;
        cycle();
        idle();
        lu_done_valid = 1; lu_done_rd = 9; lu_done_data = 64'd5;
        cycle();
        idle();
        lu_issue_valid = 1; lu_issue_rd = 9;
        cycle();
        lu_issue_valid = 0;
        n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin n_fail++; $display("FAIL reissue_write: got we=%b addr=%0d want we=1 addr=9", rf_we, rf_waddr); end
        dec_rs1 = 9; dec_use_rs1 = 1;
        #1;
        n_tests++; if (sb_hazard !== 1'b1) begin n_fail++; $display("FAIL reissue_set_wins: got %b want 1", sb_hazard); end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        alu_wb_valid = 1; alu_wb_rd = 4; alu_wb_data = 64'h44;
        lu_issue_valid = 1; lu_issue_rd = 15;
        lu_done_valid = 1; lu_done_rd = 16; lu_done_data = 64'h16;
        cycle();
        lu_issue_valid = 0;
        lu_done_rd = 17; lu_done_data = 64'h17;
        cycle();
        lu_done_valid = 0;
        n_tests++; if (lu_done_ready !== 1'b0 || rf_we !== 1'b1) begin n_fail++; $display("FAIL mid_setup: got ready=%b we=%b want ready=0 we=1", lu_done_ready, rf_we); end
        dec_rs1 = 15; dec_use_rs1 = 1;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_rf_we: got %b want 0", rf_we); end
        n_tests++; if (rf_waddr !== 5'd0 || rf_wdata !== 64'd0) begin n_fail++; $display("FAIL mid_rf_addr_data: got %0d/%0h want 0/0", rf_waddr, rf_wdata); end
        n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL mid_stall: got %b want 0", stall_req); end
        n_tests++; if (lu_done_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", lu_done_ready); end
        n_tests++; if (sb_hazard !== 1'b0) begin n_fail++; $display("FAIL mid_hazard: got %b want 0", sb_hazard); end
        m_reset();
        idle();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            dec_rs1 = 5'(r); dec_use_rs1 = 1;
            #1;
            n_tests++; if (sb_hazard !== 1'b0) begin n_fail++; $display("FAIL post_reset_pend_x%0d: got %b want 0", r, sb_hazard); end
        end
        idle();
        cycle();
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL post_reset_empty: got we=%b want 0", rf_we); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            alu_wb_valid = m_stall ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 6);
            alu_wb_rd = 5'($urandom_range(0, 31)); alu_wb_data = {$urandom(), $urandom()};
            lu_issue_valid = ($urandom_range(0, 9) < 3); lu_issue_rd = 5'($urandom_range(0, 31));
            lu_done_valid = ($urandom_range(0, 9) < 4); lu_done_rd = 5'($urandom_range(0, 31));
            lu_done_data = {$urandom(), $urandom()};
            dec_rs1 = 5'($urandom_range(0, 31)); dec_rs2 = 5'($urandom_range(0, 31));
            dec_rd = 5'($urandom_range(0, 31));
            dec_use_rs1 = 1'($urandom_range(0, 1)); dec_use_rs2 = 1'($urandom_range(0, 1));
            dec_use_rd = 1'($urandom_range(0, 1));
            #1;
            n_tests++; if (sb_hazard !== exp_hazard()) begin n_fail++; $display("FAIL rnd_hazard_c%0d: got %b want %b", c, sb_hazard, exp_hazard()); end
            n_tests++; if (lu_done_ready !== (m_q.size() < FIFO_DEPTH)) begin n_fail++; $display("FAIL rnd_ready_c%0d: got %b want %b", c, lu_done_ready, m_q.size() < FIFO_DEPTH); end
            cycle();
            n_tests++; if (rf_we !== m_we) begin n_fail++; $display("FAIL rnd_we_c%0d: got %b want %b", c, rf_we, m_we); end
            if (m_we) begin
                n_tests++; if (rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin n_fail++; $display("FAIL rnd_wport_c%0d: got x%0d=%0h want x%0d=%0h", c, rf_waddr, rf_wdata, m_waddr, m_wdata); end
            end
            n_tests++; if (stall_req !== m_stall) begin n_fail++; $display("FAIL rnd_stall_c%0d: got %b want %b", c, stall_req, m_stall); end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_hazard();
        test_starve();
        test_full();
        test_rd0();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Sequential arbiter that shares the single register-file write port between the in-order ALU writeback stage and a long-latency unit (multiply/divide/load-miss). It sits between the datapath's writeback stage and the register file. Long-latency results are buffered and the core is stalled to guarantee forward progress. The block also keeps a pending-destination scoreboard that decode queries for RAW/WAW hazards.

## Interface
- XLEN, 64, data width
- REG_AW, 5, register address width
- FIFO_DEPTH, 2, long-unit result buffer entries
- STARVE_MAX, 4, cycles a buffered result may wait before a forced stall

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- alu_wb_valid / alu_wb_rd / alu_wb_data  in  1 / REG_AW / XLEN  ALU writeback request
- lu_issue_valid / lu_issue_rd  in  1 / REG_AW  long op issued; marks rd pending
- lu_done_valid / lu_done_rd / lu_done_data  in  1 / REG_AW / XLEN  long op result
- lu_done_ready  out  1  result accepted when valid&&ready
- dec_rs1 / dec_rs2 / dec_rd  in  REG_AW  decode operand addresses
- dec_use_rs1 / dec_use_rs2 / dec_use_rd  in  1  operand-valid flags
- sb_hazard  out  1  combinational: any used operand is pending
- stall_req  out  1  registered; core must hold decode and drive alu_wb_valid=0
- rf_we / rf_waddr / rf_wdata  out  1 / REG_AW / XLEN  registered write port

## Operation
- Reset (reset=0): FIFO empty, scoreboard cleared, starve counter 0.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, lu_done_ready=1, sb_hazard=0. All inputs are ignored during reset.
- FIFO: lu_done_ready = !full. An accepted result is pushed as {rd,data}. Push and pop in the same cycle when full is not allowed, because ready is already low.
- Port select, evaluated each cycle:
  - alu_wb_valid=1: ALU wins.
  - Otherwise, with FIFO non-empty: the FIFO head is written and popped.
  - Otherwise: rf_we=0.
- rd=0 from either source: the entry is consumed/popped but rf_we stays 0.
- Starve counter: increments each cycle the FIFO is non-empty and the head is not popped. It clears on pop.
- When the counter reaches STARVE_MAX-1 with the head still blocked, stall_req=1 from the next cycle.
- stall_req holds until the cycle after the head pops. If alu_wb_valid=1 while stall_req=1, that is a protocol violation; the head still wins.
- Scoreboard: 2^REG_AW pending bits.
  - lu_issue_valid with rd≠0 sets the bit.
  - Popping the head clears the bit for head rd.
  - If set and clear hit the same rd in one cycle, set wins.
  - Bit 0 is never set.
- sb_hazard = (use_rs1&&pend[rs1]) | (use_rs2&&pend[rs2]) | (use_rd&&pend[rd]).
  - It uses pre-edge state, so there is no forwarding: a register retiring this cycle still reads as a hazard until the next cycle.
- Decode must not issue while sb_hazard=1. This guarantees ALU and FIFO never target the same pending rd.

## Timing
- ALU path latency: alu_wb_valid sampled at edge k, rf_we=1 after edge k (one register stage).
- Long path latency:
  - Result accepted at edge k and pushed.
  - Earliest write at edge k+1, with rf_we visible after k+1.
  - Pending bit cleared at edge k+1.
- Bypass: none; an empty FIFO still costs one buffer cycle.
- Throughput: one write per cycle.
- Forced stall: with FIFO_DEPTH=2, a full buffer with continuous ALU traffic drains within STARVE_MAX+1 cycles per entry.
- Reset mid-operation: buffered results and pending bits are discarded. rf_we drops asynchronously.

## Structure
- Shared package riscv_pkg:
  - XLEN and REG_AW constants.
  - wb_req_t typedef {rd, data}.
- Sub-module wb_fifo: parameterized FIFO_DEPTH circular buffer with wrap-around read/write pointers and a count, exposing full, empty, push, pop and head.
- Top level holds the select logic, starve counter, scoreboard and output registers.

## Test plan
- Reset release, ALU write x5=7 at edge k: rf_we=1, rf_waddr=5, rf_wdata=7 after k. lu_done_ready=1, sb_hazard=0.
- Issue rd=12, then decode rs1=12: sb_hazard=1. Done x12=168 with ALU idle: rf write at accept+1, then sb_hazard=0 the following cycle.
- ALU continuous plus done x20=12: stall_req rises after STARVE_MAX cycles. x20 written during the stall, stall_req falls the cycle after.
- Two dones back-to-back with ALU busy: FIFO full, lu_done_ready=0. Third done held until a pop; entries retire in order.
- Done with rd=0, data 0xFF: popped, rf_we stays 0, no hazard change. Issue and retire same rd in one cycle: bit remains set.
- Assert reset with 2 buffered entries: outputs return to reset values immediately. After release the FIFO is empty and all pending bits are 0.
